// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Which requester owns (or last owned) the memory
    typedef enum logic {
        SIDE_IF = 1'b0,
        SIDE_D  = 1'b1
    } side_t;

    // Instruction fetches are always full-word transfers
    localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_perf_counters.sv
// Free-running 32-bit event counters for the arbiter (grants per side and
// IDLE cycles with both sides pending). Wrap naturally at 2^32.
module mem_arb_perf_counters (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        inc_if,
    input  logic        inc_d,
    input  logic        inc_conf,
    output logic [31:0] cnt_if,
    output logic [31:0] cnt_d,
    output logic [31:0] cnt_conf
);

    // Count one event per cycle on each strobe; cleared by reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_if   <= '0;
            cnt_d    <= '0;
            cnt_conf <= '0;
        end else begin
            if (inc_if)   cnt_if   <= cnt_if + 32'd1;
            if (inc_d)    cnt_d    <= cnt_d + 32'd1;
            if (inc_conf) cnt_conf <= cnt_conf + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch port and
// the load/store port. Round-robin on conflict, req/ack sequencing to memory,
// one-cycle ready strobes back to the core, and a watchdog that aborts hung
// accesses (TIMEOUT = 0 disables it).
// Optional build macro: MEM_ARB_PERF_EN adds the performance counters;
// without it cnt_if/cnt_d/cnt_conf read as zero.
//
// Handshake: a requester raises its request and holds it with stable fields
// until it sees its ready strobe (one cycle, in RESP); it must drop or change
// the request on the following cycle. Toward memory, m_req stays high with
// stable m_* fields until m_ack is seen for one cycle (m_rdata valid with it)
// or the watchdog aborts; acks outside the grant states are ignored.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_type,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [DATA_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_type,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [31:0]       cnt_if,
    output logic [31:0]       cnt_d,
    output logic [31:0]       cnt_conf,
    output state_t            fsm_state
);

    // Wide enough to hold TIMEOUT itself; stays legal when TIMEOUT is 0 or 1
    localparam int WD_W = $clog2(TIMEOUT + 2);

    state_t          state;
    side_t           last_gnt;
    logic [WD_W-1:0] wd_cnt;
    logic            d_pend;
    logic            gnt_d;
    logic            gnt_i;
    logic            timeout_hit;

    assign d_pend = d_rd_en | d_wr_en;
    // Data wins unless fetch is also pending and data had the last grant
    assign gnt_d  = (state == ST_IDLE) && d_pend && (!if_req || (last_gnt == SIDE_IF));
    assign gnt_i  = (state == ST_IDLE) && if_req && !gnt_d;
    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));
    assign fsm_state = state;

    // Arbitration FSM with registered memory-side and core-side outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            last_gnt <= SIDE_IF;
            wd_cnt   <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_type   <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (gnt_d) begin
                        state    <= ST_GNT_D;
                        last_gnt <= SIDE_D;
                        m_req    <= 1'b1;
                        m_we     <= d_wr_en;   // store wins over a load
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        m_type   <= d_type;
                    end else if (gnt_i) begin
                        state    <= ST_GNT_I;
                        last_gnt <= SIDE_IF;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_addr   <= if_addr;
                        m_wdata  <= '0;
                        m_type   <= MEM_TYPE_WORD;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    // An ack in the timeout cycle still completes normally
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= ST_RESP;
                        if (state == ST_GNT_I) begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            d_rdata <= m_rdata;
                            d_ready <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        m_req <= 1'b0;
                        state <= ST_RESP;
                        err   <= 1'b1;
                        if (state == ST_GNT_I) begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end else begin
                            d_rdata <= '0;
                            d_ready <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic conf_seen;
    assign conf_seen = (state == ST_IDLE) && if_req && d_pend;

    mem_arb_perf_counters u_perf (
        .CLK      (CLK),
        .Reset    (Reset),
        .inc_if   (gnt_i),
        .inc_d    (gnt_d),
        .inc_conf (conf_seen),
        .cnt_if   (cnt_if),
        .cnt_d    (cnt_d),
        .cnt_conf (cnt_conf)
    );
`else
    assign cnt_if   = '0;
    assign cnt_d    = '0;
    assign cnt_conf = '0;
`endif

endmodule
